fuzzy_risk_scheduler: RTL and testbench

Time-shares one fuzzy risk engine among NUM_SITES rainfall/soil-moisture sensor sites. The engine is free-running and has no handshake. This block does three things:
- Arbitrates periodic and on-demand conversion requests round-robin.
- Drives the engine operands and holds them stable for the engine's pipeline latency, then captures the risk result.
- Tags each result with its site and maintains a per-site hysteretic alarm.

---
 rtl/fuzzy_pkg.sv | 9 +
 rtl/fuzzy_rr_arbiter.sv | 21 ++
 rtl/fuzzy_risk_scheduler.sv | 152 +++++++++++++++
 tb/tb_fuzzy_risk_scheduler.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fuzzy_pkg.sv
// fuzzy_pkg: shared FSM states, sensor constants and operand clamp
package fuzzy_pkg;
  localparam int SENSOR_MAX = 100;
  localparam int RISK_W = 8;
  typedef enum logic [1:0] {IDLE, WAIT, CAPTURE} state_e;
  function automatic logic [RISK_W-1:0] clamp(input logic [RISK_W-1:0] v);
    return (v > RISK_W'(SENSOR_MAX)) ? RISK_W'(SENSOR_MAX) : v;
  endfunction
endpackage

// File: rtl/fuzzy_rr_arbiter.sv
// fuzzy_rr_arbiter: first pending site at or after the pointer, wrapping
module fuzzy_rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  pend,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] grant,
  output logic          any
);
  logic [IW-1:0] idx;
  always_comb begin
    grant = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr) + k) % N);
      if (pend[idx]) grant = idx;
    end
  end
  assign any = |pend;
endmodule

// File: rtl/fuzzy_risk_scheduler.sv
// fuzzy_risk_scheduler: round-robin time-share of one fuzzy risk engine across sensor sites
// RISK_AVG_EN: report the rounded mean of each site's previous and current risk
module fuzzy_risk_scheduler
  import fuzzy_pkg::*;
#(
  parameter int NUM_SITES = 4,
  parameter int ENGINE_LAT = 5,
  parameter int SAMPLE_DIV = 1000,
  parameter int ALARM_ON = 200,
  parameter int ALARM_OFF = 150,
  localparam int SW = $clog2(NUM_SITES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [8*NUM_SITES-1:0] site_rain,
  input  logic [8*NUM_SITES-1:0] site_soil,
  input  logic [NUM_SITES-1:0]   site_req,
  output logic [RISK_W-1:0]      eng_rain,
  output logic [RISK_W-1:0]      eng_soil,
  input  logic [RISK_W-1:0]      eng_risk,
  output logic                   risk_valid,
  output logic [SW-1:0]          risk_site,
  output logic [RISK_W-1:0]      risk_value,
  output logic [NUM_SITES-1:0]   alarm,
  output logic                   busy
);
  localparam int TW = $clog2(SAMPLE_DIV);
  localparam int LW = $clog2(ENGINE_LAT + 1);
  state_e state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [NUM_SITES-1:0] pend_q, pend_d, alarm_q, alarm_d, set_v;
  logic [SW-1:0] ptr_q, ptr_d, site_q, site_d, rsite_q, rsite_d, grant;
  logic [LW-1:0] wcnt_q, wcnt_d;
  logic [RISK_W-1:0] rain_q, rain_d, soil_q, soil_d, rval_q, rval_d, cap_val;
  logic [RISK_W-1:0] rain_a [NUM_SITES];
  logic [RISK_W-1:0] soil_a [NUM_SITES];
  logic rv_q, rv_d, any, tick_wrap;
`ifdef RISK_AVG_EN
  logic [RISK_W-1:0] hist_q [NUM_SITES];
  logic [RISK_W-1:0] hist_d [NUM_SITES];
  logic [NUM_SITES-1:0] seen_q, seen_d;
  logic [RISK_W:0] sum;
`endif
  fuzzy_rr_arbiter #(.N(NUM_SITES)) u_arb (
    .pend  (pend_q),
    .ptr   (ptr_q),
    .grant (grant),
    .any   (any)
  );
  always_comb begin
    for (int i = 0; i < NUM_SITES; i++) begin
      rain_a[i] = site_rain[8*i +: 8];
      soil_a[i] = site_soil[8*i +: 8];
    end
    tick_wrap = en && (tick_q == TW'(SAMPLE_DIV - 1));
    tick_d = !en ? tick_q : tick_wrap ? '0 : tick_q + 1'b1;
    set_v = site_req | {NUM_SITES{tick_wrap}};
    pend_d = pend_q | set_v;
    state_d = state_q;
    ptr_d = ptr_q;
    site_d = site_q;
    wcnt_d = wcnt_q;
    rain_d = rain_q;
    soil_d = soil_q;
    rv_d = 1'b0;
    rsite_d = rsite_q;
    rval_d = rval_q;
    alarm_d = alarm_q;
`ifdef RISK_AVG_EN
    sum = {1'b0, hist_q[site_q]} + {1'b0, eng_risk} + 9'd1;
    cap_val = seen_q[site_q] ? sum[RISK_W:1] : eng_risk;
    hist_d = hist_q;
    seen_d = seen_q;
`else
    cap_val = eng_risk;
`endif
    case (state_q)
      IDLE: if (en && any) begin
        state_d = WAIT;
        site_d = grant;
        wcnt_d = LW'(ENGINE_LAT - 1);
        rain_d = clamp(rain_a[grant]);
        soil_d = clamp(soil_a[grant]);
      end
      WAIT: begin
        state_d = (wcnt_q == '0) ? CAPTURE : WAIT;
        wcnt_d = (wcnt_q == '0) ? wcnt_q : wcnt_q - 1'b1;
      end
      CAPTURE: begin
        state_d = IDLE;
        rv_d = 1'b1;
        rval_d = cap_val;
        rsite_d = site_q;
        // a same-cycle request or tick for the captured site keeps it pending
        pend_d = (pend_q & ~(NUM_SITES'(1) << site_q)) | set_v;
        ptr_d = (site_q == SW'(NUM_SITES - 1)) ? '0 : site_q + 1'b1;
        alarm_d[site_q] = (cap_val >= RISK_W'(ALARM_ON)) ? 1'b1 :
                          (cap_val < RISK_W'(ALARM_OFF)) ? 1'b0 : alarm_q[site_q];
`ifdef RISK_AVG_EN
        hist_d[site_q] = cap_val;
        seen_d[site_q] = 1'b1;
`endif
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tick_q <= '0;
      pend_q <= '0;
      ptr_q <= '0;
      site_q <= '0;
      wcnt_q <= '0;
      rain_q <= '0;
      soil_q <= '0;
      rv_q <= 1'b0;
      rsite_q <= '0;
      rval_q <= '0;
      alarm_q <= '0;
`ifdef RISK_AVG_EN
      for (int i = 0; i < NUM_SITES; i++) hist_q[i] <= '0;
      seen_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      tick_q <= tick_d;
      pend_q <= pend_d;
      ptr_q <= ptr_d;
      site_q <= site_d;
      wcnt_q <= wcnt_d;
      rain_q <= rain_d;
      soil_q <= soil_d;
      rv_q <= rv_d;
      rsite_q <= rsite_d;
      rval_q <= rval_d;
      alarm_q <= alarm_d;
`ifdef RISK_AVG_EN
      hist_q <= hist_d;
      seen_q <= seen_d;
`endif
    end
  end
  assign eng_rain = rain_q;
  assign eng_soil = soil_q;
  assign risk_valid = rv_q;
  assign risk_site = rsite_q;
  assign risk_value = rval_q;
  assign alarm = alarm_q;
  assign busy = (state_q != IDLE);
endmodule

// File: tb/tb_fuzzy_risk_scheduler.sv
// tb_fuzzy_risk_scheduler: directed checks of arbitration, latency, alarm and periodic sampling
module tb_fuzzy_risk_scheduler;
  logic clk = 1'b0;
  logic rst_n, en, en2;
  logic [31:0] site_rain, site_soil;
  logic [3:0] site_req, site_req2;
  logic [7:0] eng_rain, eng_soil, eng_risk, risk_value;
  logic [7:0] eng_rain2, eng_soil2, eng_risk2, risk_value2;
  logic risk_valid, busy, rv2, busy2;
  logic [1:0] risk_site, rsite2;
  logic [3:0] alarm, alarm2;
  int checks = 0;
  int fails = 0;
  always #5 clk = ~clk;
  fuzzy_risk_scheduler u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .site_rain(site_rain), .site_soil(site_soil),
    .site_req(site_req), .eng_rain(eng_rain), .eng_soil(eng_soil), .eng_risk(eng_risk),
    .risk_valid(risk_valid), .risk_site(risk_site), .risk_value(risk_value),
    .alarm(alarm), .busy(busy)
  );
  fuzzy_risk_scheduler #(.ENGINE_LAT(2), .SAMPLE_DIV(20)) u_tick (
    .clk(clk), .rst_n(rst_n), .en(en2), .site_rain(site_rain), .site_soil(site_soil),
    .site_req(site_req2), .eng_rain(eng_rain2), .eng_soil(eng_soil2), .eng_risk(eng_risk2),
    .risk_valid(rv2), .risk_site(rsite2), .risk_value(risk_value2),
    .alarm(alarm2), .busy(busy2)
  );
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    en2 = 1'b0;
    site_req = '0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask
  task automatic wait_pulse(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!risk_valid && n < 40);
    if (!risk_valid) n = -1;
  endtask
  task automatic request(input logic [3:0] r);
    site_req = r;
    step();
    site_req = '0;
  endtask
  initial begin
    int n, held, busy_n, cnt, last_site;
    int tq[$];
    int sq[$];
    int et[5] = '{24, 28, 32, 36, 44};
    int es[5] = '{0, 1, 2, 3, 0};
    int exp_rain[4] = '{100, 99, 100, 7};
    int exp_soil[4] = '{100, 100, 55, 0};
    rst_n = 1'b0;
    en = 1'b1;
    en2 = 1'b0;
    site_req = '0;
    site_req2 = '0;
    eng_risk = 8'd77;
    eng_risk2 = 8'd33;
    site_rain = {8'd7, 8'd120, 8'd99, 8'd255};
    site_soil = {8'd0, 8'd55, 8'd101, 8'd100};
    do_reset();
    chk("rst_eng_rain", eng_rain, 0);
    chk("rst_eng_soil", eng_soil, 0);
    chk("rst_valid", risk_valid, 0);
    chk("rst_value", risk_value, 0);
    chk("rst_alarm", alarm, 0);
    chk("rst_busy", busy, 0);
    // single request on site 2: clamped operands held for six edges
    request(4'b0100);
    n = 0;
    held = 1;
    busy_n = 0;
    do begin
      step();
      n++;
      if (busy) busy_n++;
      if (eng_rain !== 8'd100 || eng_soil !== 8'd55) held = 0;
    end while (!risk_valid && n < 40);
    chk("t1_latency", n, 7);
    chk("t1_held", held, 1);
    chk("t1_busy_cycles", busy_n, 6);
    chk("t1_site", risk_site, 2);
    chk("t1_value", risk_value, 77);
    step();
    chk("t1_valid_one_cycle", risk_valid, 0);
    chk("t1_busy_idle", busy, 0);
    // three simultaneous requests, then a late re-request of site 0
    do_reset();
    request(4'b1011);
    wait_pulse(n);
    chk("t2_lat0", n, 7);
    chk("t2_site0", risk_site, 0);
    chk("t2_rain0", eng_rain, exp_rain[0]);
    chk("t2_soil0", eng_soil, exp_soil[0]);
    wait_pulse(n);
    chk("t2_lat1", n, 7);
    chk("t2_site1", risk_site, 1);
    chk("t2_rain1", eng_rain, exp_rain[1]);
    chk("t2_soil1", eng_soil, exp_soil[1]);
    for (int i = 0; i < 6; i++) step();
    chk("t2_capture_busy", busy, 1);
    request(4'b0001);
    chk("t2_valid3", risk_valid, 1);
    chk("t2_site3", risk_site, 3);
    chk("t2_rain3", eng_rain, exp_rain[3]);
    chk("t2_soil3", eng_soil, exp_soil[3]);
    wait_pulse(n);
    chk("t2_lat_re0", n, 7);
    chk("t2_site_re0", risk_site, 0);
    // hysteretic alarm on site 1
    do_reset();
    eng_risk = 8'd210;
    request(4'b0010);
    wait_pulse(n);
    chk("al_value210", risk_value, 210);
    chk("al_210", alarm, 4'b0010);
    eng_risk = 8'd170;
    request(4'b0010);
    wait_pulse(n);
    chk("al_170", alarm, 4'b0010);
    eng_risk = 8'd140;
    request(4'b0010);
    wait_pulse(n);
    chk("al_140", alarm, 4'b0000);
    // reset asserted mid-WAIT
    do_reset();
    eng_risk = 8'd210;
    request(4'b0010);
    wait_pulse(n);
    chk("mr_alarm_pre", alarm, 4'b0010);
    request(4'b0100);
    for (int i = 0; i < 3; i++) step();
    chk("mr_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mr_eng_rain", eng_rain, 0);
    chk("mr_busy", busy, 0);
    chk("mr_alarm", alarm, 0);
    chk("mr_site", risk_site, 0);
    chk("mr_value", risk_value, 0);
    step();
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (risk_valid) cnt++;
    end
    chk("mr_no_valid", cnt, 0);
    request(4'b1010);
    wait_pulse(n);
    chk("mr_ptr_lat", n, 7);
    chk("mr_ptr_site", risk_site, 1);
    // history averaging, or pass-through when averaging is absent
    do_reset();
    eng_risk = 8'd100;
    request(4'b0001);
    wait_pulse(n);
    chk("avg_first", risk_value, 100);
    eng_risk = 8'd201;
    request(4'b0001);
    wait_pulse(n);
`ifdef RISK_AVG_EN
    chk("avg_second", risk_value, 151);
`else
    chk("avg_second", risk_value, 201);
`endif
    // periodic sampling on the SAMPLE_DIV=20, ENGINE_LAT=2 instance
    do_reset();
    en2 = 1'b1;
    for (int c = 1; c <= 46; c++) begin
      step();
      if (rv2) begin
        tq.push_back(c);
        sq.push_back(int'(rsite2));
      end
    end
    chk("per_count", tq.size(), 5);
    for (int i = 0; i < 5 && i < tq.size(); i++) begin
      chk($sformatf("per_time%0d", i), tq[i], et[i]);
      chk($sformatf("per_site%0d", i), sq[i], es[i]);
    end
    en2 = 1'b0;
    cnt = 0;
    last_site = -1;
    for (int c = 1; c <= 30; c++) begin
      step();
      if (rv2) begin
        cnt++;
        last_site = int'(rsite2);
      end
    end
    chk("per_off_count", cnt, 1);
    chk("per_off_site", last_site, 1);
    tq.delete();
    sq.delete();
    en2 = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (rv2) begin
        tq.push_back(c);
        sq.push_back(int'(rsite2));
      end
    end
    chk("per_resume_count", tq.size(), 2);
    if (tq.size() >= 2) begin
      chk("per_resume_t0", tq[0], 4);
      chk("per_resume_s0", sq[0], 2);
      chk("per_resume_t1", tq[1], 8);
      chk("per_resume_s1", sq[1], 3);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
